seq_divider32b: RTL and testbench

SEQ_DIVIDER32B -- requirements
Module: seq_divider32b

---
 rtl/seq_divider32b_pkg.sv | 35 +++
 rtl/seq_divider32b_adder.sv | 25 ++
 rtl/seq_divider32b.sv | 178 +++++++++++++++++
 tb/tb_seq_divider32b.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider32b_pkg.sv
// Shared definitions for the 32-bit sequential restoring divider:
// FSM state encoding, iteration count and the divide-by-zero quotient,
// plus small two's-complement helpers used by the optional signed path.
package seq_divider32b_pkg;

  // Controller states: waiting, iterating, and finishing / publishing results
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // One quotient bit per RUN iteration, 32 iterations in total
  localparam logic [5:0]  ITER_COUNT    = 6'd32;

  // Quotient reported when the divisor is zero (all ones)
  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  // Two's-complement negation of a 32-bit value
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return (~v) + 32'd1;
  endfunction

  // Negate only when en is set; used for magnitude conversion and sign fix-up
  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic en);
    logic [31:0] res;
    if (en) begin
      res = neg32(v);
    end else begin
      res = v;
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_divider32b_adder.sv
// 32-bit adder/subtractor used for the divider's trial subtraction.
// With SUB=1 it computes A - B as A + ~B + 1; COUT=1 then means no borrow.
module Adder32b
  import seq_divider32b_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        SUB,
  output logic [31:0] S,
  output logic        COUT
);

  logic [31:0] b_eff_s;
  logic [32:0] sum_s;

  // Invert the second operand and inject the carry-in when subtracting
  always_comb begin
    b_eff_s = B ^ {32{SUB}};
    sum_s   = {1'b0, A} + {1'b0, b_eff_s} + {32'd0, SUB};
  end

  assign S    = sum_s[31:0];
  assign COUT = sum_s[32];

endmodule

// File: rtl/seq_divider32b.sv
// 32-bit sequential restoring divider, one quotient bit per clock, MSB first.
// Timeline: START accepted on edge 0, operand load on edge 1, 32 iterations on
// edges 2..33, results published with a one-cycle DONE pulse on edge 34.
// A zero divisor takes a fast path and completes on the edge after acceptance.
// Optional feature: define SEQ_DIVIDER32B_SIGNED_EN to compile in the signed
// (truncating) division path controlled by the SIGNED input; without it the
// SIGNED input is ignored and every operation is unsigned.
module seq_divider32b
  import seq_divider32b_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        SIGNED,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] Q,
  output logic [31:0] R,
  output logic        DIV0
);

  // Controller and datapath state
  state_e      state_r;
  logic [5:0]  cnt_r;      // 0 = load cycle, 1..32 = iteration number
  logic [31:0] a_r;        // dividend as captured at START
  logic [31:0] b_r;        // divisor as captured at START
  logic [31:0] rem_r;      // partial remainder
  logic [31:0] dvd_r;      // dividend shift register, fills with quotient bits
  logic [31:0] dvs_r;      // divisor magnitude used by the subtractor

  // Combinational datapath signals
  logic [32:0] partial_s;
  logic [31:0] diff_s;
  logic        no_borrow_s;
  logic        commit_s;
  logic [31:0] rem_next_s;
  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;
  logic [31:0] q_final_s;
  logic [31:0] r_final_s;

`ifdef SEQ_DIVIDER32B_SIGNED_EN
  logic        sgn_r;
  logic        neg_a_s;
  logic        neg_q_s;
`else
  logic        unused_signed_s;
`endif

  // Shift the next dividend bit into the remainder to form the 33-bit partial
  always_comb begin
    partial_s = {rem_r, dvd_r[31]};
  end

  Adder32b u_trial_sub (
    .A    (partial_s[31:0]),
    .B    (dvs_r),
    .SUB  (1'b1),
    .S    (diff_s),
    .COUT (no_borrow_s)
  );

  // Commit the subtraction when the partial is at least the divisor
  always_comb begin
    commit_s = partial_s[32] | no_borrow_s;
    if (commit_s) begin
      rem_next_s = diff_s;
    end else begin
      rem_next_s = partial_s[31:0];
    end
  end

`ifdef SEQ_DIVIDER32B_SIGNED_EN
  // Magnitudes for the unsigned core and sign correction of the final results
  always_comb begin
    neg_a_s   = sgn_r & a_r[31];
    neg_q_s   = sgn_r & (a_r[31] ^ b_r[31]);
    mag_a_s   = cond_neg32(a_r, neg_a_s);
    mag_b_s   = cond_neg32(b_r, sgn_r & b_r[31]);
    q_final_s = cond_neg32(dvd_r, neg_q_s);
    r_final_s = cond_neg32(rem_r, neg_a_s);
  end
`else
  // Unsigned-only build: operands and results pass straight through
  always_comb begin
    mag_a_s   = a_r;
    mag_b_s   = b_r;
    q_final_s = dvd_r;
    r_final_s = rem_r;
  end

  assign unused_signed_s = SIGNED;
`endif

  // Main FSM: accept, load, iterate, publish; all outputs are registered
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
      cnt_r   <= 6'd0;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      rem_r   <= 32'd0;
      dvd_r   <= 32'd0;
      dvs_r   <= 32'd0;
`ifdef SEQ_DIVIDER32B_SIGNED_EN
      sgn_r   <= 1'b0;
`endif
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      Q       <= 32'd0;
      R       <= 32'd0;
      DIV0    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // The DONE cycle still reads as IDLE; START is held off until it ends
          if (START && !DONE) begin
            a_r     <= A;
            b_r     <= B;
`ifdef SEQ_DIVIDER32B_SIGNED_EN
            sgn_r   <= SIGNED;
`endif
            cnt_r   <= 6'd0;
            BUSY    <= 1'b1;
            state_r <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (cnt_r == 6'd0) begin
            if (b_r == 32'd0) begin
              // Divide-by-zero fast path: publish immediately, no iterations
              DONE    <= 1'b1;
              DIV0    <= 1'b1;
              Q       <= DIV0_QUOTIENT;
              R       <= a_r;
              BUSY    <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              rem_r <= 32'd0;
              dvd_r <= mag_a_s;
              dvs_r <= mag_b_s;
              cnt_r <= 6'd1;
            end
          end else begin
            rem_r <= rem_next_s;
            dvd_r <= {dvd_r[30:0], commit_s};
            if (cnt_r == ITER_COUNT) begin
              state_r <= ST_FIN;
            end else begin
              cnt_r <= cnt_r + 6'd1;
            end
          end
        end

        ST_FIN: begin
          DONE    <= 1'b1;
          DIV0    <= 1'b0;
          Q       <= q_final_s;
          R       <= r_final_s;
          BUSY    <= 1'b0;
          cnt_r   <= 6'd0;
          state_r <= ST_IDLE;
        end

        default: begin
          BUSY    <= 1'b0;
          cnt_r   <= 6'd0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider32b.sv
// Self-checking bench for seq_divider32b: expected results are pushed to a
// scoreboard queue when an operation is started and compared at DONE.
module tb_seq_divider32b;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [31:0] A;
  logic [31:0] B;
  logic        SIGNED;
  logic        BUSY;
  logic        DONE;
  logic [31:0] Q;
  logic [31:0] R;
  logic        DIV0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        div0;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  seq_divider32b dut (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .A      (A),
    .B      (B),
    .SIGNED (SIGNED),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .Q      (Q),
    .R      (R),
    .DIV0   (DIV0)
  );

  always #5 CLK = ~CLK;

  // Reference model of the divider result
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    exp_t e;
    logic use_signed;
    use_signed = sgn;
`ifndef SEQ_DIVIDER32B_SIGNED_EN
    use_signed = 1'b0;
`endif
    e.div0 = (b == 32'd0);
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
    end else if (use_signed) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.q = 32'h8000_0000;
        e.r = 32'd0;
      end else begin
        e.q = $signed(a) / $signed(b);
        e.r = $signed(a) % $signed(b);
      end
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Start an operation after one spacer edge; returns #1 after the accept edge
  task automatic issue(input logic [31:0] a_i, input logic [31:0] b_i, input logic s_i);
    @(posedge CLK); #1;
    START  = 1'b1;
    A      = a_i;
    B      = b_i;
    SIGNED = s_i;
    sb_q.push_back(model(a_i, b_i, s_i));
    @(posedge CLK); #1;
    START  = 1'b0;
  endtask

  // Wait up to budget edges for DONE; lat = edges waited, 0 on timeout
  task automatic wait_done(input int budget, output int lat);
    lat = 0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge CLK); #1;
      if (DONE === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b0; A = 32'd0; B = 32'd0; SIGNED = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({BUSY, DONE, DIV0, Q, R} !== {1'b0, 1'b0, 1'b0, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_state: got BUSY=%b DONE=%b DIV0=%b Q=%h R=%h, expected all zero", BUSY, DONE, DIV0, Q, R);
    end
    RST = 1'b0;
  endtask

  task automatic test_basic();
    exp_t e;
    int   bad_busy = 0;
    issue(32'd100, 32'd7, 1'b0);
    for (int k = 1; k <= 33; k++) begin
      @(posedge CLK); #1;
      if (BUSY !== 1'b1 || DONE !== 1'b0) bad_busy++;
    end
    checks++;
    if (bad_busy != 0) begin
      errors++;
      $display("FAIL basic_busy: got %0d bad cycles on edges 1-33, expected 0", bad_busy);
    end
    @(posedge CLK); #1;
    checks++;
    if (DONE !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_edge34: got DONE=%b BUSY=%b, expected DONE=1 BUSY=0", DONE, BUSY);
    end
    e = sb_q.pop_front();
    checks++;
    if ({Q, R, DIV0} !== {e.q, e.r, e.div0}) begin
      errors++;
      $display("FAIL basic_result: got Q=%h R=%h DIV0=%b, expected Q=%h R=%h DIV0=%b", Q, R, DIV0, e.q, e.r, e.div0);
    end
    @(posedge CLK); #1;
    checks++;
    if (DONE !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: got DONE=%b one cycle later, expected 0", DONE);
    end
  endtask

  task automatic test_max_div0();
    exp_t e;
    int   lat;
    issue(32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_done(40, lat);
    checks++;
    if (lat != 34) begin
      errors++;
      $display("FAIL max_latency: got %0d, expected 34", lat);
    end
    e = sb_q.pop_front();
    checks++;
    if ({Q, R, DIV0} !== {e.q, e.r, e.div0}) begin
      errors++;
      $display("FAIL max_result: got Q=%h R=%h DIV0=%b, expected Q=%h R=%h DIV0=%b", Q, R, DIV0, e.q, e.r, e.div0);
    end
    issue(32'd5, 32'd0, 1'b0);
    wait_done(40, lat);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL div0_latency: got %0d, expected 1", lat);
    end
    e = sb_q.pop_front();
    checks++;
    if ({Q, R, DIV0} !== {e.q, e.r, e.div0}) begin
      errors++;
      $display("FAIL div0_result: got Q=%h R=%h DIV0=%b, expected Q=%h R=%h DIV0=%b", Q, R, DIV0, e.q, e.r, e.div0);
    end
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({Q, R, DIV0, BUSY} !== {e.q, e.r, e.div0, 1'b0}) begin
      errors++;
      $display("FAIL div0_hold: got Q=%h R=%h DIV0=%b BUSY=%b, expected Q=%h R=%h DIV0=%b BUSY=0", Q, R, DIV0, BUSY, e.q, e.r, e.div0);
    end
  endtask

  task automatic test_signed();
    logic [31:0] av [5] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFFB, 32'd7, 32'hFFFF_FF9C};
    logic [31:0] bv [5] = '{32'd2, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFF9};
    exp_t e;
    int   lat;
    for (int i = 0; i < 5; i++) begin
      issue(av[i], bv[i], 1'b1);
      wait_done(40, lat);
      checks++;
      if (lat != ((bv[i] == 32'd0) ? 1 : 34)) begin
        errors++;
        $display("FAIL signed_latency[%0d]: got %0d, expected %0d", i, lat, (bv[i] == 32'd0) ? 1 : 34);
      end
      e = sb_q.pop_front();
      checks++;
      if ({Q, R, DIV0} !== {e.q, e.r, e.div0}) begin
        errors++;
        $display("FAIL signed_result[%0d]: got Q=%h R=%h DIV0=%b, expected Q=%h R=%h DIV0=%b", i, Q, R, DIV0, e.q, e.r, e.div0);
      end
    end
  endtask

  task automatic test_start_while_busy();
    exp_t e;
    int   lat;
    issue(32'd100, 32'd7, 1'b0);
    repeat (4) @(posedge CLK);
    #1;
    START = 1'b1; A = 32'd1; B = 32'd1;
    @(posedge CLK); #1;
    START = 1'b0;
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("FAIL busy_ignore_busy: got BUSY=%b after edge 5, expected 1", BUSY);
    end
    wait_done(40, lat);
    checks++;
    if (lat != 29) begin
      errors++;
      $display("FAIL busy_ignore_latency: got DONE %0d edges after edge 5, expected 29", lat);
    end
    e = sb_q.pop_front();
    checks++;
    if ({Q, R, DIV0} !== {e.q, e.r, e.div0}) begin
      errors++;
      $display("FAIL busy_ignore_result: got Q=%h R=%h DIV0=%b, expected Q=%h R=%h DIV0=%b", Q, R, DIV0, e.q, e.r, e.div0);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    issue(32'd1000, 32'd33, 1'b0);
    wait_done(40, lat);
    e = sb_q.pop_front();
    checks++;
    if (lat != 34 || {Q, R, DIV0} !== {e.q, e.r, e.div0}) begin
      errors++;
      $display("FAIL b2b_first: got lat=%0d Q=%h R=%h, expected lat=34 Q=%h R=%h", lat, Q, R, e.q, e.r);
    end
    START = 1'b1; A = 32'd77; B = 32'd5; SIGNED = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_cycle_start: got BUSY=%b, expected 0 (START ignored)", BUSY);
    end
    @(posedge CLK); #1;
    START = 1'b0;
    sb_q.push_back(model(32'd77, 32'd5, 1'b0));
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("FAIL b2b_next_start: got BUSY=%b, expected 1", BUSY);
    end
    wait_done(40, lat);
    e = sb_q.pop_front();
    checks++;
    if (lat != 34 || {Q, R, DIV0} !== {e.q, e.r, e.div0}) begin
      errors++;
      $display("FAIL b2b_second: got lat=%0d Q=%h R=%h, expected lat=34 Q=%h R=%h", lat, Q, R, e.q, e.r);
    end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    int   lat;
    int   seen = 0;
    issue(32'd100, 32'd7, 1'b0);
    repeat (9) @(posedge CLK);
    #1;
    RST = 1'b1; START = 1'b1; A = 32'd3; B = 32'd1;
    @(posedge CLK); #1;
    RST = 1'b0; START = 1'b0;
    sb_q.delete();
    checks++;
    if ({BUSY, DONE, DIV0, Q, R} !== {1'b0, 1'b0, 1'b0, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL abort_reset_state: got BUSY=%b DONE=%b DIV0=%b Q=%h R=%h, expected all zero", BUSY, DONE, DIV0, Q, R);
    end
    for (int k = 0; k < 40; k++) begin
      @(posedge CLK); #1;
      if (DONE !== 1'b0 || BUSY !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d cycles with DONE/BUSY set, expected 0", seen);
    end
    issue(32'd1000, 32'd10, 1'b0);
    wait_done(40, lat);
    e = sb_q.pop_front();
    checks++;
    if (lat != 34 || {Q, R, DIV0} !== {e.q, e.r, e.div0}) begin
      errors++;
      $display("FAIL abort_restart: got lat=%0d Q=%h R=%h DIV0=%b, expected lat=34 Q=%h R=%h DIV0=%b", lat, Q, R, DIV0, e.q, e.r, e.div0);
    end
  endtask

  task automatic test_random();
    exp_t        e;
    int          lat;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      case (i % 4)
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      issue(ra, rb, rs);
      wait_done(40, lat);
      e = sb_q.pop_front();
      checks++;
      if (lat != ((rb == 32'd0) ? 1 : 34) || {Q, R, DIV0} !== {e.q, e.r, e.div0}) begin
        errors++;
        $display("FAIL random[%0d] A=%h B=%h S=%b: got lat=%0d Q=%h R=%h DIV0=%b, expected Q=%h R=%h DIV0=%b",
                 i, ra, rb, rs, lat, Q, R, DIV0, e.q, e.r, e.div0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_div0();
    test_signed();
    test_start_while_busy();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
